// File: rtl/corr_seq_ctrl_pkg.sv
// Shared types and sizing helpers for the correlator pair sequencer.
package corr_seq_ctrl_pkg;

  localparam int unsigned DEF_NUM_PAIRS = 4;
  localparam int unsigned DEF_LEN_W     = 16;
  localparam int unsigned DATA_W        = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN,
    ST_GAP,
    ST_DONE
  } state_t;

  // Index width for a pair count; a single pair still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/corr_seq_ctrl_pipeline_stage.sv
// Single register stage with asynchronous active-low clear.
module corr_seq_ctrl_pipeline_stage #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_resetn,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) o_q <= '0;
    else           o_q <= i_d;
  end

endmodule

// File: rtl/corr_seq_ctrl.sv
// Sequences NUM_PAIRS product blocks through an external accumulator and
// forwards each pair's sum on a valid/ready result stream.
module corr_seq_ctrl
  import corr_seq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PAIRS = DEF_NUM_PAIRS,
  parameter int unsigned LEN_W     = DEF_LEN_W
) (
  input  logic                         i_clk,
  input  logic                         i_resetn,
  input  logic                         i_start,
  input  logic [LEN_W-1:0]             i_len,
  input  logic [DATA_W-1:0]            i_data,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic [DATA_W-1:0]            o_acc_data,
  output logic                         o_acc_valid,
  output logic                         o_acc_last,
  input  logic [DATA_W-1:0]            i_acc_result,
  input  logic                         i_acc_valid,
  output logic [DATA_W-1:0]            o_res_data,
  output logic [idx_w(NUM_PAIRS)-1:0]  o_res_idx,
  output logic                         o_res_valid,
  input  logic                         i_res_ready,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_err
);

  localparam int unsigned IDX_W = idx_w(NUM_PAIRS);

  state_t             state_q, state_d;
  logic               start_q;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   pair_q;
  logic [DATA_W-1:0]  res_data_q;
  logic [IDX_W-1:0]   res_idx_q;
  logic               res_valid_q;
  logic               err_q;
  logic               slot_free;
  logic               beat_last;
  logic               pair_last;

  corr_seq_ctrl_pipeline_stage #(
    .WIDTH (1)
  ) u_start_stage (
    .i_clk    (i_clk),
    .i_resetn (i_resetn),
    .i_d      (i_start),
    .o_q      (start_q)
  );

  assign slot_free = !res_valid_q || i_res_ready;
  assign beat_last = i_valid && (cnt_q == len_q - LEN_W'(1));
  assign pair_last = (pair_q == IDX_W'(NUM_PAIRS - 1));

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_q)   state_d = ST_WAIT;
      ST_WAIT: if (slot_free) state_d = ST_RUN;
      ST_RUN:  if (beat_last) state_d = ST_GAP;
      ST_GAP:  state_d = pair_last ? ST_DONE : ST_WAIT;
      ST_DONE: if (slot_free) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    o_busy      = (state_q != ST_IDLE);
    o_ready     = (state_q == ST_RUN);
    o_acc_valid = (state_q == ST_RUN) && i_valid;
    o_acc_data  = (state_q == ST_RUN) ? i_data : '0;
    o_acc_last  = (state_q == ST_RUN) && beat_last;
    o_done      = (state_q == ST_DONE) && slot_free;
  end

  // Beat and pair counters; a dropped beat mid-block restarts the same pair
  // because the accumulator has already cleared its partial sum.
  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      len_q  <= '0;
      cnt_q  <= '0;
      pair_q <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_q) begin
            len_q  <= (i_len == '0) ? LEN_W'(1) : i_len;
            cnt_q  <= '0;
            pair_q <= '0;
            err_q  <= 1'b0;
          end
        end
        ST_RUN: begin
          if (i_valid) begin
            cnt_q <= beat_last ? '0 : cnt_q + LEN_W'(1);
          end else if (cnt_q != '0) begin
            cnt_q <= '0;
            err_q <= 1'b1;
          end
        end
        ST_GAP: begin
          if (!i_acc_valid) err_q  <= 1'b1;
          if (!pair_last)   pair_q <= pair_q + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      res_data_q  <= '0;
      res_idx_q   <= '0;
      res_valid_q <= 1'b0;
    end else if ((state_q == ST_GAP) && i_acc_valid) begin
      res_data_q  <= i_acc_result;
      res_idx_q   <= pair_q;
      res_valid_q <= 1'b1;
    end else if (i_res_ready) begin
      res_valid_q <= 1'b0;
    end
  end

  assign o_res_data  = res_data_q;
  assign o_res_idx   = res_idx_q;
  assign o_res_valid = res_valid_q;
  assign o_err       = err_q;

endmodule

// File: tb/tb_corr_seq_ctrl.sv
// Randomised bench: block producer, accumulator model and result scoreboard.
module tb_corr_seq_ctrl;
  import corr_seq_ctrl_pkg::*;

  localparam int NP = 4;
  localparam int LW = 16;

  logic          i_clk = 1'b0;
  logic          i_resetn;
  logic          i_start;
  logic [LW-1:0] i_len;
  logic [31:0]   i_data;
  logic          i_valid;
  logic          o_ready;
  logic [31:0]   o_acc_data;
  logic          o_acc_valid;
  logic          o_acc_last;
  logic [31:0]   i_acc_result;
  logic          i_acc_valid;
  logic [31:0]   o_res_data;
  logic [1:0]    o_res_idx;
  logic          o_res_valid;
  logic          i_res_ready;
  logic          o_busy;
  logic          o_done;
  logic          o_err;

  corr_seq_ctrl #(
    .NUM_PAIRS (NP),
    .LEN_W     (LW)
  ) dut (
    .i_clk        (i_clk),
    .i_resetn     (i_resetn),
    .i_start      (i_start),
    .i_len        (i_len),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .o_acc_data   (o_acc_data),
    .o_acc_valid  (o_acc_valid),
    .o_acc_last   (o_acc_last),
    .i_acc_result (i_acc_result),
    .i_acc_valid  (i_acc_valid),
    .o_res_data   (o_res_data),
    .o_res_idx    (o_res_idx),
    .o_res_valid  (o_res_valid),
    .i_res_ready  (i_res_ready),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int          idx;
    logic [31:0] data;
  } res_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int  cfg_len_eff = 1;
  int  drop_pair   = -1;
  int  drop_after  = 0;
  int  kill_pair   = -1;
  int  ready_mode  = 0;
  bit  data_one    = 1'b0;
  bit  rnd_idle    = 1'b0;
  bit  start_mid   = 1'b0;

  int          drv_pair, drv_beat;
  logic [31:0] drv_sum;
  bit          dropped, start_req, mid_started;
  logic [31:0] acc, nxt_res;
  bit          nxt_valid;
  res_t        expq[$];
  int          last_cyc, stall_cnt, done_cnt, res_cnt;
  bit          stall_used, exp_err;
  bit          prev_rv, prev_rdy;
  logic [31:0] prev_data;
  logic [1:0]  prev_idx;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    drv_pair = 0; drv_beat = 0; drv_sum = '0;
    dropped = 0; start_req = 0; mid_started = 0;
    acc = '0; nxt_res = '0; nxt_valid = 0;
    expq.delete();
    last_cyc = -100; stall_cnt = 0; stall_used = 0;
    done_cnt = 0; res_cnt = 0; exp_err = 0;
    prev_rv = 0; prev_rdy = 0; prev_data = '0; prev_idx = '0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ":busy"},      32'(o_busy),      0);
    check({tag, ":ready"},     32'(o_ready),     0);
    check({tag, ":acc_valid"}, 32'(o_acc_valid), 0);
    check({tag, ":acc_last"},  32'(o_acc_last),  0);
    check({tag, ":acc_data"},  o_acc_data,       0);
    check({tag, ":res_valid"}, 32'(o_res_valid), 0);
    check({tag, ":res_data"},  o_res_data,       0);
    check({tag, ":res_idx"},   32'(o_res_idx),   0);
    check({tag, ":done"},      32'(o_done),      0);
    check({tag, ":err"},       32'(o_err),       0);
  endtask

  // Sampling side of a cycle: accumulator model, scoreboard and protocol checks.
  task automatic monitor();
    res_t e;
    nxt_valid = 0;
    if (o_acc_valid) begin
      if (o_acc_last) begin
        nxt_res   = acc + o_acc_data;
        nxt_valid = (drv_pair != kill_pair);
        if (drv_pair == kill_pair) exp_err = 1;
        acc = '0;
      end else begin
        acc = acc + o_acc_data;
      end
      check("acc_last", 32'(o_acc_last), 32'(drv_beat == cfg_len_eff - 1));
      check("acc_data", o_acc_data, i_data);
    end else begin
      acc = '0;
    end

    if (stall_cnt > 0) begin
      check("stall_ready", 32'(o_ready), 0);
      check("stall_busy",  32'(o_busy),  1);
      stall_cnt--;
    end

    if (o_ready && i_valid) begin
      drv_sum = drv_sum + i_data;
      drv_beat++;
      if (drv_beat == cfg_len_eff) begin
        last_cyc = cyc;
        if (drv_pair != kill_pair) expq.push_back('{drv_pair, drv_sum});
        if (ready_mode == 2 && !stall_used) begin
          stall_used = 1;
          stall_cnt  = 11;
        end
        drv_pair++;
        drv_beat = 0;
        drv_sum  = '0;
      end
    end

    if (o_res_valid && !prev_rv) check("res_latency", 32'(cyc - last_cyc), 2);
    if (prev_rv && !prev_rdy) begin
      check("hold_valid", 32'(o_res_valid), 1);
      check("hold_data",  o_res_data,       prev_data);
      check("hold_idx",   32'(o_res_idx),   32'(prev_idx));
    end
    if (o_res_valid && i_res_ready) begin
      res_cnt++;
      if (expq.size() == 0) begin
        check("res_unexpected", 1, 0);
      end else begin
        e = expq.pop_front();
        check("res_idx",  32'(o_res_idx), 32'(e.idx));
        check("res_data", o_res_data,     e.data);
      end
    end
    if (o_done) done_cnt++;
    prev_rv   = o_res_valid;
    prev_rdy  = i_res_ready;
    prev_data = o_res_data;
    prev_idx  = o_res_idx;
  endtask

  task automatic tick();
    @(posedge i_clk);
    cyc++;
    #1;
    i_acc_valid  = nxt_valid;
    i_acc_result = nxt_res;
    i_start      = start_req;
    start_req    = 0;
    if (o_ready) begin
      if (drv_pair == drop_pair && drv_beat == drop_after && !dropped) begin
        i_valid  = 1'b0;
        dropped  = 1;
        drv_beat = 0;
        drv_sum  = '0;
        exp_err  = 1;
      end else if (rnd_idle && drv_beat == 0 && $urandom_range(3) == 0) begin
        i_valid = 1'b0;
      end else begin
        i_valid = 1'b1;
        i_data  = data_one ? 32'd1 : $urandom;
      end
    end else begin
      i_valid = 1'b0;
      i_data  = $urandom;
    end
    if (start_mid && !mid_started && o_ready && drv_pair == 1 && drv_beat == 1) begin
      i_start     = 1'b1;
      mid_started = 1;
    end
    i_res_ready = (stall_cnt > 0) ? 1'b0 : (ready_mode == 1) ? 1'($urandom_range(1)) : 1'b1;
    @(negedge i_clk);
    monitor();
  endtask

  task automatic run(input int len, input int dp, input int da, input int kp,
                     input bit one, input int rm, input bit idle, input bit smid,
                     input string name);
    int n;
    model_reset();
    cfg_len_eff = (len == 0) ? 1 : len;
    drop_pair = dp; drop_after = da; kill_pair = kp;
    data_one = one; ready_mode = rm; rnd_idle = idle; start_mid = smid;
    i_len     = LW'(len);
    start_req = 1;
    n = 0;
    while (done_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    if (done_cnt == 0) check({name, ":timeout"}, 0, 1);
    repeat (6) tick();
    check({name, ":done_once"},   32'(done_cnt), 1);
    check({name, ":results"},     32'(res_cnt), 32'(NP - ((kp >= 0 && kp < NP) ? 1 : 0)));
    check({name, ":queue_empty"}, 32'(expq.size()), 0);
    check({name, ":err"},         32'(o_err), 32'(exp_err));
    check({name, ":busy_after"},  32'(o_busy), 0);
  endtask

  task automatic reset_mid();
    int n;
    model_reset();
    cfg_len_eff = 3; drop_pair = -1; kill_pair = -1;
    data_one = 0; ready_mode = 0; rnd_idle = 0; start_mid = 0;
    i_len = LW'(3);
    start_req = 1;
    n = 0;
    while (!(drv_pair == 2 && drv_beat == 1) && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) check("rst_mid:timeout", 0, 1);
    check("rst_mid:in_run", 32'(o_ready), 1);
    @(posedge i_clk);
    #2;
    i_resetn = 1'b0;
    @(negedge i_clk);
    check_zero("rst_mid");
    model_reset();
    i_valid = 1'b0; i_acc_valid = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_resetn = 1'b1;
    repeat (3) tick();
    check_zero("rst_after");
  endtask

  initial begin
    int len, eff, dp, da;
    model_reset();
    i_resetn = 1'b0; i_start = 1'b0; i_len = '0; i_data = '0; i_valid = 1'b0;
    i_acc_result = '0; i_acc_valid = 1'b0; i_res_ready = 1'b0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check_zero("reset");
    @(posedge i_clk);
    #1;
    i_resetn = 1'b1;
    repeat (2) tick();

    run(4, -1, 0, -1, 1, 0, 0, 0, "basic");
    run(4, -1, 0, -1, 0, 2, 0, 0, "stall");
    run(3,  1, 2, -1, 0, 0, 0, 0, "drop");
    run(0, -1, 0, -1, 0, 0, 0, 0, "len0");
    run(5, -1, 0,  2, 0, 1, 0, 0, "acckill");
    run(4, -1, 0, -1, 0, 1, 1, 1, "midstart");
    reset_mid();
    run(3, -1, 0, -1, 0, 0, 0, 0, "post_reset");

    for (int r = 0; r < 6; r++) begin
      len = int'($urandom_range(7));
      eff = (len == 0) ? 1 : len;
      dp  = ($urandom_range(1) == 1 && eff >= 2) ? int'($urandom_range(NP - 1)) : -1;
      da  = (eff >= 2) ? int'($urandom_range(eff - 1, 1)) : 0;
      run(len, dp, da, -1, 0, 1, 1, 0, "random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/corr_seq_ctrl.md
CORR_SEQ_CTRL -- requirements
Module: corr_seq_ctrl

Interface
REQ-001 Parameter NUM_PAIRS, default 4: antenna pairs sequenced per run.
REQ-002 Parameter LEN_W, default 16: width of the snapshot-count field.
REQ-003 i_clk  in  1  single clock; all logic rising-edge.
REQ-004 i_resetn  in  1  asynchronous, active-low reset.
REQ-005 i_start  in  1  one-cycle pulse; starts a run; ignored unless IDLE.
REQ-006 i_len  in  LEN_W  snapshots per pair; sampled at start; 0 treated as 1.
REQ-007 i_data / i_valid / o_ready  in 32 / in 1 / out 1  product stream, one pair block after another.
REQ-008 o_acc_data / o_acc_valid / o_acc_last  out 32/1/1  drive to accumulator data/valid/last.
REQ-009 i_acc_result / i_acc_valid  in 32/1  accumulator sum, and its valid flag (asserted one cycle after last).
REQ-010 o_res_data / o_res_idx / o_res_valid / i_res_ready  out 32 / out clog2(NUM_PAIRS) / out 1 / in 1  result stream.
REQ-011 o_busy / o_done / o_err  out 1  run active / one-cycle run-complete pulse / sticky gap error.

Function
REQ-012 FSM states SHALL be IDLE, WAIT, RUN, GAP, DONE.
REQ-013 IDLE: on i_start latch len (0 becomes 1), set pair=0, go to WAIT.
REQ-014 WAIT: go to RUN when result slot is free (o_res_valid=0, or o_res_valid and i_res_ready in the same cycle).
REQ-015 RUN: o_ready=1; o_acc_valid=i_valid; o_acc_data=i_data; count increments on each i_valid.
REQ-016 o_acc_last SHALL equal i_valid && (count==len-1); on that beat go to GAP.
REQ-017 Accumulator clears whenever valid is low, so a gap inside a block corrupts the sum.
REQ-018 If i_valid drops after the first beat of a block: set o_err (sticky until next i_start); reset count to 0; restart the same pair; stay in RUN.
REQ-019 GAP lasts exactly one cycle: o_ready=0, o_acc_valid=0.
REQ-020 In GAP, if i_acc_valid: load o_res_data=i_acc_result, o_res_idx=pair, o_res_valid=1.
REQ-021 If i_acc_valid is absent in GAP: set o_err and load no result.
REQ-022 GAP exit: pair==NUM_PAIRS-1 goes to DONE; otherwise pair+1 and go to WAIT.
REQ-023 Back-to-back blocks are therefore separated by at least one idle accumulator cycle.
REQ-024 Result handshake: o_res_valid holds, and data and idx stay stable, until i_res_ready; clears on the transfer cycle unless it is reloaded in that same cycle.
REQ-025 DONE: wait for the final result to transfer, pulse o_done for one cycle, return to IDLE.
REQ-026 o_busy=1 in every state except IDLE.
REQ-027 o_ready=0 outside RUN.
REQ-028 i_start outside IDLE SHALL be ignored with no effect.
REQ-029 Latency: last beat at cycle t gives o_res_valid at t+2.

Reset
REQ-030 Asynchronous on i_resetn low: state=IDLE; counters, idx and data=0.
REQ-031 On reset, every valid/ready/last/done/err/busy output=0.
REQ-032 Reset mid-run SHALL abandon the run with no result or done emitted; the pending result is discarded.

Structure
REQ-033 Shared package holds: state enum, default NUM_PAIRS/LEN_W, data width 32, and the idx width function.
REQ-034 One sub-module is natural: pipeline_stage (WIDTH=1) registers i_start before the FSM. All other logic is the FSM plus two counters in this module.

Verification
REQ-035 len=4, NUM_PAIRS=4, data=1 each beat, always ready -> results (idx 0..3, data 4) each at t+2 after last; o_done once; o_err=0.
REQ-036 i_res_ready held low for 10 cycles after first result -> FSM holds in WAIT; o_ready=0; result 0 stable; resumes when ready rises.
REQ-037 len=3, i_valid dropped after beat 2 of pair 1 -> o_err=1; pair 1 restarts; final results still count 3 beats.
REQ-038 i_len=0 -> each pair is one beat with o_acc_last on that beat; results equal the single datum.
REQ-039 Reset asserted in RUN of pair 2 -> all outputs 0 next edge; later i_start runs cleanly from pair 0.
REQ-040 i_start pulsed during RUN -> no effect on count, pair or outputs.
